// File: rtl/cmd_fifo_burst_sync.sv
// Single-clock DDR command FIFO with burst-atomic commit: write-burst beats reach
// the pop side only once the whole burst is in. Optional sticky error flags: CMD_FIFO_ERR_EN.
module cmd_fifo_burst_sync #(
    parameter int TYPE_WIDTH = 2,
    parameter int ADDR_WIDTH = 27,
    parameter int BRST_WIDTH = 6,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16,
    parameter int DEPTH      = 64,
    parameter int AFULL_LVL  = 48
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      io_push_valid,
    output logic                      io_push_ready,
    input  logic [TYPE_WIDTH-1:0]     io_push_cmd_type,
    input  logic [ADDR_WIDTH-1:0]     io_push_addr,
    input  logic [BRST_WIDTH-1:0]     io_push_burst_cnt,
    input  logic [DATA_WIDTH-1:0]     io_push_wt_data,
    input  logic [MASK_WIDTH-1:0]     io_push_wt_mask,
    input  logic                      io_pop_valid,
    output logic                      io_pop_ready,
    output logic [TYPE_WIDTH-1:0]     io_pop_cmd_type,
    output logic [ADDR_WIDTH-1:0]     io_pop_addr,
    output logic [BRST_WIDTH-1:0]     io_pop_burst_cnt,
    output logic [DATA_WIDTH-1:0]     io_pop_wt_data,
    output logic [MASK_WIDTH-1:0]     io_pop_wt_mask,
    output logic                      io_pop_last,
    output logic [$clog2(DEPTH):0]    io_count,
    output logic                      io_almost_full,
    output logic                      io_burst_open
`ifdef CMD_FIFO_ERR_EN
    ,
    output logic                      io_err_ovf,
    output logic                      io_err_unf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_P = PW'(AFULL_LVL);
    localparam logic [TYPE_WIDTH-1:0] T_IDE = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] T_WT  = TYPE_WIDTH'(2);

    typedef struct packed {
        logic [TYPE_WIDTH-1:0] cmd_type;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BRST_WIDTH-1:0] burst_cnt;
        logic [DATA_WIDTH-1:0] wt_data;
        logic [MASK_WIDTH-1:0] wt_mask;
        logic                  last;
    } entry_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_e;

    entry_t                mem_q [DEPTH];
    state_e                state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         cmt_ptr_q, cmt_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [BRST_WIDTH-1:0] blen_q, blen_d;
    logic [BRST_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

    logic [PW-1:0]         used;
    logic                  push_fire;
    logic                  pop_fire;
    logic                  wr_en;
    entry_t                wr_entry;
    entry_t                head;

    // Occupancy counts written-but-uncommitted beats so an open burst reserves its space.
    assign used          = wr_ptr_q - rd_ptr_q;
    assign io_push_ready = (used < DEPTH_P);
    assign io_pop_ready  = (cmt_ptr_q != rd_ptr_q);
    assign push_fire     = io_push_valid & io_push_ready;
    assign pop_fire      = io_pop_valid & io_pop_ready;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cmt_ptr_d  = cmt_ptr_q;
        rd_ptr_d   = rd_ptr_q + PW'(pop_fire);
        blen_d     = blen_q;
        beat_cnt_d = beat_cnt_q;
        wr_en      = 1'b0;
        wr_entry   = '{cmd_type:  io_push_cmd_type,
                       addr:      io_push_addr,
                       burst_cnt: io_push_burst_cnt,
                       wt_data:   io_push_wt_data,
                       wt_mask:   io_push_wt_mask,
                       last:      1'b0};

        if (push_fire) begin
            unique case (state_q)
                S_IDLE: begin
                    if (io_push_cmd_type == T_WT) begin
                        wr_en      = 1'b1;
                        blen_d     = io_push_burst_cnt;
                        beat_cnt_d = '0;
                        if (io_push_burst_cnt == '0) begin
                            wr_entry.last = 1'b1;
                            cmt_ptr_d     = wr_ptr_q + PW'(1);
                        end else begin
                            state_d = S_BURST;
                        end
                    end else if (io_push_cmd_type != T_IDE) begin
                        // Non-write commands are single-beat whatever burst_cnt says.
                        wr_en         = 1'b1;
                        wr_entry.last = 1'b1;
                        cmt_ptr_d     = wr_ptr_q + PW'(1);
                    end
                end
                S_BURST: begin
                    wr_en      = 1'b1;
                    beat_cnt_d = beat_cnt_q + BRST_WIDTH'(1);
                    if (beat_cnt_q == blen_q - BRST_WIDTH'(1)) begin
                        wr_entry.last = 1'b1;
                        cmt_ptr_d     = wr_ptr_q + PW'(1);
                        beat_cnt_d    = '0;
                        state_d       = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        wr_ptr_d = wr_ptr_q + PW'(wr_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            rd_ptr_q   <= '0;
            blen_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cmt_ptr_q  <= cmt_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            blen_q     <= blen_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    assign head             = mem_q[rd_ptr_q[AW-1:0]];
    assign io_pop_cmd_type  = head.cmd_type;
    assign io_pop_addr      = head.addr;
    assign io_pop_burst_cnt = head.burst_cnt;
    assign io_pop_wt_data   = head.wt_data;
    assign io_pop_wt_mask   = head.wt_mask;
    assign io_pop_last      = io_pop_ready & head.last;
    assign io_count         = cmt_ptr_q - rd_ptr_q;
    assign io_almost_full   = (used >= AFULL_P);
    assign io_burst_open    = (state_q == S_BURST);

`ifdef CMD_FIFO_ERR_EN
    logic err_ovf_q;
    logic err_unf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            if (io_push_valid & ~io_push_ready) err_ovf_q <= 1'b1;
            if (io_pop_valid & ~io_pop_ready)   err_unf_q <= 1'b1;
        end
    end

    assign io_err_ovf = err_ovf_q;
    assign io_err_unf = err_unf_q;
`endif

endmodule

// File: tb/tb_cmd_fifo_burst_sync.sv
// Bench for cmd_fifo_burst_sync: vector table, hand-written corner sequences and a
// randomized run scored against a queue-based model of committed/pending entries.
module tb_cmd_fifo_burst_sync;

    logic         clk;
    logic         rst;
    logic         io_push_valid;
    logic         io_push_ready;
    logic [1:0]   io_push_cmd_type;
    logic [26:0]  io_push_addr;
    logic [5:0]   io_push_burst_cnt;
    logic [127:0] io_push_wt_data;
    logic [15:0]  io_push_wt_mask;
    logic         io_pop_valid;
    logic         io_pop_ready;
    logic [1:0]   io_pop_cmd_type;
    logic [26:0]  io_pop_addr;
    logic [5:0]   io_pop_burst_cnt;
    logic [127:0] io_pop_wt_data;
    logic [15:0]  io_pop_wt_mask;
    logic         io_pop_last;
    logic [6:0]   io_count;
    logic         io_almost_full;
    logic         io_burst_open;
`ifdef CMD_FIFO_ERR_EN
    logic         io_err_ovf;
    logic         io_err_unf;
`endif

    cmd_fifo_burst_sync dut (
        .clk               (clk),
        .rst               (rst),
        .io_push_valid     (io_push_valid),
        .io_push_ready     (io_push_ready),
        .io_push_cmd_type  (io_push_cmd_type),
        .io_push_addr      (io_push_addr),
        .io_push_burst_cnt (io_push_burst_cnt),
        .io_push_wt_data   (io_push_wt_data),
        .io_push_wt_mask   (io_push_wt_mask),
        .io_pop_valid      (io_pop_valid),
        .io_pop_ready      (io_pop_ready),
        .io_pop_cmd_type   (io_pop_cmd_type),
        .io_pop_addr       (io_pop_addr),
        .io_pop_burst_cnt  (io_pop_burst_cnt),
        .io_pop_wt_data    (io_pop_wt_data),
        .io_pop_wt_mask    (io_pop_wt_mask),
        .io_pop_last       (io_pop_last),
        .io_count          (io_count),
        .io_almost_full    (io_almost_full),
        .io_burst_open     (io_burst_open)
`ifdef CMD_FIFO_ERR_EN
        ,
        .io_err_ovf        (io_err_ovf),
        .io_err_unf        (io_err_unf)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    typedef struct packed {
        logic [1:0]   ty;
        logic [26:0]  addr;
        logic [5:0]   bc;
        logic [127:0] data;
        logic [15:0]  mask;
        logic         last;
    } ent_t;

    ent_t exp_q[$];    // committed entries, head at index 0
    ent_t pend_q[$];   // beats of the burst currently being pushed
    int   brem;        // beats still owed to the open burst
    logic ovf_m;
    logic unf_m;
    int   errors;
    int   checks;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_q.delete();
        brem  = 0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        io_push_valid     = 1'b0;
        io_push_cmd_type  = 2'd0;
        io_push_addr      = '0;
        io_push_burst_cnt = '0;
        io_push_wt_data   = '0;
        io_push_wt_mask   = '0;
        io_pop_valid      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Drives one cycle from a negedge: checks current outputs against the model,
    // clocks, then advances the model. pushed reports whether the beat was taken.
    task automatic step(input logic pv, input logic [1:0] ty, input logic [26:0] ad,
                        input logic [5:0] bc, input logic [127:0] d, input logic [15:0] m,
                        input logic popv, output logic pushed);
        logic exp_pr;
        logic pop_f;
        ent_t e;
        io_push_valid     = pv;
        io_push_cmd_type  = ty;
        io_push_addr      = ad;
        io_push_burst_cnt = bc;
        io_push_wt_data   = d;
        io_push_wt_mask   = m;
        io_pop_valid      = popv;
        #1;
        exp_pr = (exp_q.size() + pend_q.size()) < 64;
        chk("push_ready", io_push_ready, exp_pr);
        chk("pop_ready", io_pop_ready, exp_q.size() > 0);
        chk("count", io_count, exp_q.size());
        chk("almost_full", io_almost_full, (exp_q.size() + pend_q.size()) >= 48);
        chk("burst_open", io_burst_open, brem > 0);
        if (exp_q.size() > 0) begin
            chk("head_type", io_pop_cmd_type, exp_q[0].ty);
            chk("head_addr", io_pop_addr, exp_q[0].addr);
            chk("head_bcnt", io_pop_burst_cnt, exp_q[0].bc);
            chk("head_data", io_pop_wt_data, exp_q[0].data);
            chk("head_mask", io_pop_wt_mask, exp_q[0].mask);
            chk("head_last", io_pop_last, exp_q[0].last);
        end else begin
            chk("empty_last", io_pop_last, 1'b0);
        end
`ifdef CMD_FIFO_ERR_EN
        chk("err_ovf", io_err_ovf, ovf_m);
        chk("err_unf", io_err_unf, unf_m);
`endif
        pop_f  = popv && (exp_q.size() > 0);
        pushed = pv && exp_pr;
        if (pv && !exp_pr) ovf_m = 1'b1;
        if (popv && exp_q.size() == 0) unf_m = 1'b1;
        @(posedge clk);
        if (pop_f) void'(exp_q.pop_front());
        if (pushed) begin
            e = '{ty: ty, addr: ad, bc: bc, data: d, mask: m, last: 1'b0};
            if (brem > 0) begin
                e.last = (brem == 1);
                pend_q.push_back(e);
                brem--;
                if (brem == 0) begin
                    while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
                end
            end else if (ty == 2'd2) begin
                if (bc == 6'd0) begin
                    e.last = 1'b1;
                    exp_q.push_back(e);
                end else begin
                    pend_q.push_back(e);
                    brem = int'(bc);
                end
            end else if (ty != 2'd0) begin
                e.last = 1'b1;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       pv;
        logic [1:0] ty;
        logic [5:0] bc;
        logic       popv;
        logic       e_pr;
        logic       e_popr;
        logic [6:0] e_cnt;
        logic       e_open;
        logic       e_last;
    } vec_t;

    vec_t tbl[16];

    localparam logic [127:0] BASE = 128'hfedcba98_76543210_fedcba98_76543210;

    initial begin
        logic pushed;
        logic [5:0] gen_bc;
        logic [1:0] ty;
        logic [5:0] bc;
        int gen_rem;
        int budget;
        ent_t bq[$];
        ent_t be;

        errors = 0;
        checks = 0;
        model_reset();

        //            pv    ty    bc    popv  pr    popr  cnt   open  last
        tbl[0]  = '{1'b1, 2'd3, 6'd7, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 6'd0, 1'b0, 1'b1, 1'b1, 7'd1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 2'd2, 6'd3, 1'b0, 1'b1, 1'b1, 7'd1, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 2'd2, 6'd3, 1'b1, 1'b1, 1'b1, 7'd1, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 2'd2, 6'd3, 1'b0, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 2'd2, 6'd3, 1'b0, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 6'd0, 1'b1, 1'b1, 1'b1, 7'd4, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 6'd0, 1'b1, 1'b1, 1'b1, 7'd3, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 6'd0, 1'b1, 1'b1, 1'b1, 7'd2, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 6'd0, 1'b1, 1'b1, 1'b1, 7'd1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 2'd0, 6'd0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 2'd2, 6'd0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 2'd1, 6'd5, 1'b0, 1'b1, 1'b1, 7'd1, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 2'd0, 6'd0, 1'b1, 1'b1, 1'b1, 7'd2, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 2'd0, 6'd0, 1'b1, 1'b1, 1'b1, 7'd1, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 2'd0, 6'd0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0};

        rst = 1'b1;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            chk("tbl_push_ready", io_push_ready, tbl[i].e_pr);
            chk("tbl_pop_ready", io_pop_ready, tbl[i].e_popr);
            chk("tbl_count", io_count, tbl[i].e_cnt);
            chk("tbl_burst_open", io_burst_open, tbl[i].e_open);
            chk("tbl_pop_last", io_pop_last, tbl[i].e_last);
            step(tbl[i].pv, tbl[i].ty, 27'(i + 5), tbl[i].bc, 128'(i), 16'(i),
                 tbl[i].popv, pushed);
        end

        // 8-beat write burst stays hidden until its last beat, then pops intact.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk("burst_hidden", io_pop_ready, 1'b0);
            step(1'b1, 2'd2, 27'h100, 6'd7, BASE + 128'(i), 16'hffff, 1'b0, pushed);
        end
        chk("burst_visible", io_pop_ready, 1'b1);
        chk("burst_count", io_count, 7'd8);
        for (int i = 0; i < 8; i++) begin
            chk("burst_data", io_pop_wt_data, BASE + 128'(i));
            chk("burst_last", io_pop_last, i == 7);
            step(1'b0, 2'd0, 27'd0, 6'd0, 128'd0, 16'd0, 1'b1, pushed);
        end

        // Fill to full with RD; almost-full from 48, a same-cycle pop frees nothing.
        do_reset();
        for (int k = 0; k < 64; k++) begin
            chk("fill_afull", io_almost_full, k >= 48);
            chk("fill_ready", io_push_ready, 1'b1);
            step(1'b1, 2'd3, 27'(k), 6'd0, 128'(k), 16'd0, 1'b0, pushed);
        end
        chk("full_ready", io_push_ready, 1'b0);
        chk("full_count", io_count, 7'd64);
        step(1'b1, 2'd3, 27'h7ff, 6'd0, 128'd0, 16'd0, 1'b1, pushed);
        chk("full_pop_push_rejected", pushed, 1'b0);
        chk("after_pop_ready", io_push_ready, 1'b1);
        chk("after_pop_count", io_count, 7'd63);
        for (int k = 0; k < 70; k++) step(1'b0, 2'd0, 27'd0, 6'd0, 128'd0, 16'd0, 1'b1, pushed);

        // Alternating 8-beat WT and RD with continuous popping, across pointer wrap.
        do_reset();
        for (int r = 0; r < 20; r++) begin
            for (int b = 0; b < 8; b++) begin
                be = '{ty: 2'd2, addr: 27'(r), bc: 6'd7, data: 128'(r * 16 + b), mask: 16'(b), last: 1'b0};
                bq.push_back(be);
            end
            be = '{ty: 2'd3, addr: 27'(r + 1000), bc: 6'd2, data: 128'd0, mask: 16'd0, last: 1'b1};
            bq.push_back(be);
        end
        budget = 0;
        while (bq.size() > 0 && budget < 1000) begin
            chk("interleave_count_le9", io_count <= 7'd9, 1'b1);
            step(1'b1, bq[0].ty, bq[0].addr, bq[0].bc, bq[0].data, bq[0].mask, 1'b1, pushed);
            if (pushed) void'(bq.pop_front());
            budget++;
        end
        chk("interleave_done", bq.size() == 0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            chk("interleave_count_le9", io_count <= 7'd9, 1'b1);
            step(1'b0, 2'd0, 27'd0, 6'd0, 128'd0, 16'd0, 1'b1, pushed);
        end
        chk("interleave_drained", io_pop_ready, 1'b0);

        // Reset in the middle of a burst discards the uncommitted beats.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 27'h55, 6'd7, 128'(i), 16'd1, 1'b0, pushed);
        chk("midburst_open", io_burst_open, 1'b1);
        do_reset();
        chk("rst_pop_ready", io_pop_ready, 1'b0);
        chk("rst_burst_open", io_burst_open, 1'b0);
        chk("rst_count", io_count, 7'd0);
        step(1'b1, 2'd3, 27'h123, 6'd0, 128'd0, 16'd0, 1'b0, pushed);
        chk("rst_rd_type", io_pop_cmd_type, 2'd3);
        chk("rst_rd_addr", io_pop_addr, 27'h123);
        step(1'b0, 2'd0, 27'd0, 6'd0, 128'd0, 16'd0, 1'b1, pushed);
        chk("rst_rd_popped", io_pop_ready, 1'b0);

`ifdef CMD_FIFO_ERR_EN
        step(1'b0, 2'd0, 27'd0, 6'd0, 128'd0, 16'd0, 1'b1, pushed);
        chk("unf_set", io_err_unf, 1'b1);
        step(1'b0, 2'd0, 27'd0, 6'd0, 128'd0, 16'd0, 1'b0, pushed);
        chk("unf_sticky", io_err_unf, 1'b1);
`endif

        // Randomized traffic: a busy consumer phase, then a slow one that fills mid-burst.
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            gen_rem = 0;
            gen_bc  = 6'd0;
            for (int n = 0; n < 2000; n++) begin
                if (gen_rem > 0) begin
                    ty = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
                    bc = gen_bc;
                end else begin
                    ty = 2'($urandom_range(0, 3));
                    bc = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                     : 6'($urandom_range(0, 7));
                end
                step($urandom_range(0, 99) < 75, ty, 27'($urandom), bc,
                     {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
                     $urandom_range(0, 99) < ((ph == 0) ? 70 : 25), pushed);
                if (pushed) begin
                    if (gen_rem > 0) gen_rem--;
                    else if (ty == 2'd2 && bc != 6'd0) begin
                        gen_rem = int'(bc);
                        gen_bc  = bc;
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
